// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: reset fetch word, arbiter
// states and the byte-address to word-index helper.
package mem_pkg;

   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   typedef struct packed {
      logic        oor;
      logic [29:0] idx;
   } word_idx_t;

   // idx is already masked to the array depth; oor flags addr >= 4*depth
   function automatic word_idx_t word_index(input logic [31:0] addr, input int unsigned depth);
      word_idx_t   r;
      logic [32:0] lim;
      lim   = {1'b0, depth} << 2;
      r.oor = ({1'b0, addr} >= lim);
      r.idx = addr[31:2] & 30'(depth - 1);
      return r;
   endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Fetch and load/store bus between the RV32 core (master) and the memory
// responder (slave).
interface cpu_mem_responder_if;

   logic        instr_read;
   logic [31:0] instr_addr;
   logic        data_read;
   logic [3:0]  data_write;
   logic [31:0] data_addr;
   logic [31:0] data_in;
   logic [31:0] instr_out;
   logic [31:0] data_out;
   logic        instr_valid;
   logic        data_valid;
   logic        err;
   logic [15:0] stall_cnt;

   modport master (
      output instr_read, instr_addr, data_read, data_write, data_addr, data_in,
      input  instr_out, data_out, instr_valid, data_valid, err, stall_cnt
   );

   modport slave (
      input  instr_read, instr_addr, data_read, data_write, data_addr, data_in,
      output instr_out, data_out, instr_valid, data_valid, err, stall_cnt
   );

endinterface

// File: rtl/cpu_mem_responder_byte_lane_ram.sv
// Single-port synchronous RAM, read-first, with per-byte write enables.
// Contents are never reset.
module byte_lane_ram #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata <= mem[addr];
         for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder: arbitrates fetch and load/store onto one RAM port,
// data first, deferring a colliding fetch through a pending-address register.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no deferred fetch outstanding
//   ST_PEND | a fetch lost to data; pend_addr_q holds its (latest) address
module cpu_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = mem_pkg::NOP_WORD
) (
   input  logic                clk,
   input  logic                rst,
   cpu_mem_responder_if.slave  bus
);
   import mem_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [31:0] pend_addr_q;
   logic [31:0] fetch_addr;
   logic        data_acc;
   logic        serve_data, serve_fetch, load_pend, bump_stall;
   word_idx_t   d_wi, f_wi;

   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_rdata;

   logic        instr_valid_q, data_valid_q;
   logic        instr_oor_q, data_oor_q;
   logic [31:0] instr_hold_q, data_hold_q;
   logic [31:0] instr_word, data_word;
   logic        err_q;
   logic [15:0] stall_cnt_q;

   assign data_acc = bus.data_read | (|bus.data_write);

   always_comb begin
      state_d     = state_q;
      serve_data  = 1'b0;
      serve_fetch = 1'b0;
      fetch_addr  = bus.instr_addr;
      load_pend   = 1'b0;
      bump_stall  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (data_acc) begin
               serve_data = 1'b1;
               if (bus.instr_read) begin
                  load_pend  = 1'b1;
                  bump_stall = 1'b1;
                  state_d    = ST_PEND;
               end
            end else if (bus.instr_read) begin
               serve_fetch = 1'b1;
            end
         end
         ST_PEND: begin
            fetch_addr = pend_addr_q;
            if (data_acc) begin
               serve_data = 1'b1;
               load_pend  = bus.instr_read;
            end else begin
               // a fresh instr_read this cycle is ignored; the core re-requests
               serve_fetch = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign d_wi = word_index(bus.data_addr, DEPTH_WORDS);
   assign f_wi = word_index(fetch_addr, DEPTH_WORDS);

   assign ram_en   = (serve_data & ~d_wi.oor) | (serve_fetch & ~f_wi.oor);
   assign ram_we   = (serve_data & ~d_wi.oor) ? bus.data_write : 4'h0;
   assign ram_addr = serve_data ? d_wi.idx[AW-1:0] : f_wi.idx[AW-1:0];

   byte_lane_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (bus.data_in),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pend_addr_q <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_pend) pend_addr_q <= bus.instr_addr;
         if (bump_stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
         if ((serve_data && d_wi.oor) || (serve_fetch && f_wi.oor)) err_q <= 1'b1;
      end
   end

   // RAM read register is unreset, so valid flags gate it and hold registers
   // keep the last delivered word visible between accesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_valid_q <= 1'b0;
         data_valid_q  <= 1'b0;
         instr_oor_q   <= 1'b0;
         data_oor_q    <= 1'b0;
         instr_hold_q  <= NOP_WORD;
         data_hold_q   <= '0;
      end else begin
         instr_valid_q <= serve_fetch;
         data_valid_q  <= serve_data & bus.data_read;
         instr_oor_q   <= f_wi.oor;
         data_oor_q    <= d_wi.oor;
         if (instr_valid_q) instr_hold_q <= instr_word;
         if (data_valid_q)  data_hold_q  <= data_word;
      end
   end

   assign instr_word = instr_valid_q ? (instr_oor_q ? 32'h0 : ram_rdata) : instr_hold_q;
   assign data_word  = data_valid_q  ? (data_oor_q  ? 32'h0 : ram_rdata) : data_hold_q;

   assign bus.instr_out   = instr_word;
   assign bus.data_out    = data_word;
   assign bus.instr_valid = instr_valid_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.err         = err_q;
   assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder with a response scoreboard.
module tb_cpu_mem_responder;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   ivalid_seen;

   logic [31:0] exp_instr [$];
   logic [31:0] exp_data  [$];

   always #5 clk = ~clk;

   cpu_mem_responder_if bus ();

   cpu_mem_responder #(
      .DEPTH_WORDS (1024),
      .NOP_WORD    (32'h0000_0013)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // scoreboard: every valid pulse must match the oldest expected word
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (bus.data_valid === 1'b1) begin
            chk("data_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0) chk("data_out", bus.data_out, exp_data.pop_front());
         end
         if (bus.instr_valid === 1'b1) begin
            chk("instr_expected", 32'(exp_instr.size() != 0), 32'd1);
            if (exp_instr.size() != 0) chk("instr_out", bus.instr_out, exp_instr.pop_front());
         end
      end
   end

   task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] di);
      @(negedge clk);
      bus.instr_read = ir;
      bus.instr_addr = ia;
      bus.data_read  = dr;
      bus.data_write = dw;
      bus.data_addr  = da;
      bus.data_in    = di;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      drive(1'b0, 32'h0, 1'b0, we, a, d);
   endtask

   task automatic drain(input string tag);
      repeat (4) idle();
      #1;
      chk({tag, "_data_q"},  32'(exp_data.size()),  32'd0);
      chk({tag, "_instr_q"}, 32'(exp_instr.size()), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_instr_out"},   bus.instr_out,   32'h0000_0013);
      chk({tag, "_data_out"},    bus.data_out,    32'h0);
      chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
      chk({tag, "_data_valid"},  32'(bus.data_valid),  32'd0);
      chk({tag, "_err"},         32'(bus.err),         32'd0);
      chk({tag, "_stall_cnt"},   32'(bus.stall_cnt),   32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.instr_read = 1'b0; bus.instr_addr = '0;
      bus.data_read  = 1'b0; bus.data_write = '0;
      bus.data_addr  = '0;   bus.data_in    = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      do_reset();
      #1;
      chk_reset_vals("reset");

      // byte-lane merge, then load one cycle later
      store(32'h10, 32'hDEAD_BEEF, 4'hF);
      store(32'h10, 32'h0000_00AA, 4'b0001);
      exp_data.push_back(32'hDEAD_BEAA);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      idle();
      chk("load_valid_pulse", 32'(bus.data_valid), 32'd1);
      idle();
      chk("load_valid_drop", 32'(bus.data_valid), 32'd0);
      chk("load_hold", bus.data_out, 32'hDEAD_BEAA);

      // load+store same cycle is read-first, next load sees the new word
      exp_data.push_back(32'hDEAD_BEAA);
      drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'h5555_5555);
      exp_data.push_back(32'h5555_5555);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
      drain("rmw");

      // preload and fetch
      store(32'h0,  32'h0000_0093, 4'hF);
      store(32'h4,  32'h1111_1111, 4'hF);
      store(32'h8,  32'h3333_3333, 4'hF);
      store(32'h20, 32'h2222_2222, 4'hF);
      idle();
      chk("nop_before_fetch", bus.instr_out, 32'h0000_0013);
      exp_instr.push_back(32'h0000_0093);
      drive(1'b1, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();
      chk("fetch_valid_pulse", 32'(bus.instr_valid), 32'd1);
      drain("fetch");
      chk("fetch_hold", bus.instr_out, 32'h0000_0093);

      // collision: data first, fetch deferred
      exp_data.push_back(32'h2222_2222);
      exp_instr.push_back(32'h1111_1111);
      drive(1'b1, 32'h4, 1'b1, 4'h0, 32'h20, 32'h0);
      idle();
      chk("coll_data_first", 32'(bus.data_valid), 32'd1);
      chk("coll_instr_wait", 32'(bus.instr_valid), 32'd0);
      idle();
      chk("coll_instr_late", 32'(bus.instr_valid), 32'd1);
      chk("coll_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      drain("coll");

      // latest pending address wins, stall counted once
      do_reset();
      #1;
      chk_reset_vals("reset2");
      repeat (2) begin
         exp_data.push_back(32'h2222_2222);
         drive(1'b1, 32'h4, 1'b1, 4'h0, 32'h20, 32'h0);
      end
      exp_data.push_back(32'h2222_2222);
      drive(1'b1, 32'h8, 1'b1, 4'h0, 32'h20, 32'h0);
      exp_instr.push_back(32'h3333_3333);
      drain("latest");
      chk("latest_stall_cnt", 32'(bus.stall_cnt), 32'd1);

      // out-of-range access
      exp_data.push_back(32'h0);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h1000, 32'h0);
      idle();
      chk("oor_load_err", 32'(bus.err), 32'd1);
      store(32'h1000, 32'hCAFE_F00D, 4'hF);
      exp_data.push_back(32'h0000_0093);
      drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h0, 32'h0);
      drain("oor");
      chk("oor_err_sticky", 32'(bus.err), 32'd1);
      do_reset();
      #1;
      chk("oor_err_cleared", 32'(bus.err), 32'd0);

      // async reset while a fetch is pending
      drive(1'b1, 32'h8, 1'b1, 4'h0, 32'h20, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      @(negedge clk);
      bus.instr_read = 1'b0; bus.data_read = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      ivalid_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.instr_valid === 1'b1) ivalid_seen++;
      end
      chk("async_no_deferred_fetch", 32'(ivalid_seen), 32'd0);
      chk("async_stall_cnt", 32'(bus.stall_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
